// File: rtl/switch_debouncer_pkg.sv
// ============================================================================
// Module  : switch_debouncer_pkg
// Brief   : default sizing and counter-width helper for the switch debouncer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package switch_debouncer_pkg;

  localparam int SWDB_WIDTH        = 10;
  localparam int SWDB_SAMPLE_DIV   = 50000;
  localparam int SWDB_STABLE_COUNT = 8;

  // $clog2 collapses to 0 for a count of 1; a counter still needs one bit.
  function automatic int swdb_cnt_width(input int stable_count);
    int w;
    w = $clog2(stable_count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_tick_gen.sv
// ============================================================================
// Module  : sample_tick_gen
// Brief   : free-running divider; tick is high one cycle in every SAMPLE_DIV.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_tick_gen
  import switch_debouncer_pkg::*;
#(
  parameter int SAMPLE_DIV = SWDB_SAMPLE_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int               DIV_W     = swdb_cnt_width(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == C_DIV_MAX) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // With SAMPLE_DIV=1 the counter is pinned at 0 and tick is constantly high.
  assign tick = (div_q == C_DIV_MAX);

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// Module  : switch_debouncer
// Brief   : synchronise + debounce slide switches for the PIO in_port.
//           SWITCH_DEBOUNCE_CHANGE_PULSE_EN builds the sw_changed pulse flops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH        = SWDB_WIDTH,
  parameter int SAMPLE_DIV   = SWDB_SAMPLE_DIV,
  parameter int STABLE_COUNT = SWDB_STABLE_COUNT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed
);

  localparam int               CNT_W     = swdb_cnt_width(STABLE_COUNT);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_COUNT - 1);

  logic             tick;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] clean_q, clean_d;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_clean_d;

    // cnt counts consecutive disagreeing ticks; any agreeing tick restarts it.
    always_comb begin
      cnt_d       = cnt_q;
      bit_clean_d = clean_q[b];
      if (tick) begin
        if (sync2_q[b] == clean_q[b]) begin
          cnt_d = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          bit_clean_d = sync2_q[b];
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign clean_d[b] = bit_clean_d;
  end : g_bit

  assign sw_clean = clean_q;

`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  logic [WIDTH-1:0] changed_q, changed_d;

  // Registered alongside clean_q so the pulse lines up with the level edge.
  always_comb begin
    changed_d = clean_d ^ clean_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= '0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign sw_changed = changed_q;
`else
  assign sw_changed = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// Module  : tb_switch_debouncer
// Brief   : scenario tasks plus randomized traffic against a tick-window model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

  localparam int WIDTH        = 10;
  localparam int SAMPLE_DIV   = 4;
  localparam int STABLE_COUNT = 3;

`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  localparam logic [WIDTH-1:0] CHG_MASK   = '1;
  localparam int               EXP_PULSES = 1;
`else
  localparam logic [WIDTH-1:0] CHG_MASK   = '0;
  localparam int               EXP_PULSES = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_changed;

  int checks = 0;
  int passed = 0;

  switch_debouncer #(
    .WIDTH        (WIDTH),
    .SAMPLE_DIV   (SAMPLE_DIV),
    .STABLE_COUNT (STABLE_COUNT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  // Reference: raw samples delayed two edges, a sliding window of the last
  // STABLE_COUNT tick samples; a bit flips when every sample in it disagrees.
  logic [WIDTH-1:0] raw_hist[$];
  logic [WIDTH-1:0] tick_hist[$];
  logic [WIDTH-1:0] m_clean;
  logic [WIDTH-1:0] m_changed;
  int unsigned      m_edges;

  function automatic void model_reset();
    raw_hist.delete();
    raw_hist.push_back('0);
    raw_hist.push_back('0);
    tick_hist.delete();
    for (int i = 0; i < STABLE_COUNT; i++) tick_hist.push_back('0);
    m_clean   = '0;
    m_changed = '0;
    m_edges   = 0;
  endfunction

  function automatic void model_step();
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] win;
    s2 = raw_hist.pop_front();
    raw_hist.push_back(sw_raw);
    m_changed = '0;
    if ((m_edges % SAMPLE_DIV) == SAMPLE_DIV - 1) begin
      tick_hist.push_back(s2);
      void'(tick_hist.pop_front());
      win = '1;
      foreach (tick_hist[i]) win &= (tick_hist[i] ^ m_clean);
      m_changed = win;
      m_clean   = m_clean ^ win;
    end
    m_edges++;
  endfunction

  function automatic logic [WIDTH-1:0] exp_chg();
    return m_changed & CHG_MASK;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic quiesce();
    sw_raw = '0;
    assert_reset();
    cycle();
    cycle();
    reset_n = 1'b1;
    repeat ($urandom_range(0, 7)) cycle();
  endtask

  task automatic test_reset();
    int rise = -1;
    int pulses = 0;
    sw_raw = '1;
    assert_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sw_clean !== '0 || sw_changed !== '0)
        $display("FAIL reset_hold: sw_clean=%h sw_changed=%h expected 0/0", sw_clean, sw_changed);
      else passed++;
      cycle();
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== exp_chg())
        $display("FAIL reset_release: cyc %0d sw_clean=%h exp %h sw_changed=%h exp %h", n, sw_clean, m_clean, sw_changed, exp_chg());
      else passed++;
      if (rise < 0 && sw_clean === '1) rise = n;
      if (sw_changed === '1) pulses++;
    end
    checks++;
    if (rise < 1 || rise > 14) $display("FAIL reset_latency: rise at %0d expected 1..14", rise);
    else passed++;
    checks++;
    if (pulses != EXP_PULSES) $display("FAIL reset_pulse: %0d pulses expected %0d", pulses, EXP_PULSES);
    else passed++;
  endtask

  task automatic test_clean_step();
    int rise = -1;
    int pulses = 0;
    quiesce();
    sw_raw[0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== exp_chg())
        $display("FAIL clean_step: cyc %0d sw_clean=%h exp %h sw_changed=%h exp %h", n, sw_clean, m_clean, sw_changed, exp_chg());
      else passed++;
      if (rise < 0 && sw_clean[0] === 1'b1) rise = n;
      if (sw_changed[0] === 1'b1) pulses++;
    end
    checks++;
    if (rise < 11 || rise > 14) $display("FAIL step_latency: rise at %0d expected 11..14", rise);
    else passed++;
    checks++;
    if (pulses != EXP_PULSES) $display("FAIL step_pulse: %0d pulses expected %0d", pulses, EXP_PULSES);
    else passed++;
  endtask

  task automatic test_bounce();
    int rises = 0;
    int rise_at = -1;
    logic prev = 1'b0;
    quiesce();
    for (int k = 0; k < SAMPLE_DIV && (m_edges % SAMPLE_DIV) != SAMPLE_DIV - 1; k++) cycle();
    for (int n = -7; n <= 20; n++) begin
      if (n == -7) sw_raw[3] = 1'b1;
      if (n == -2) sw_raw[3] = 1'b0;
      if (n == 1)  sw_raw[3] = 1'b1;
      cycle();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== exp_chg())
        $display("FAIL bounce: cyc %0d sw_clean=%h exp %h sw_changed=%h exp %h", n, sw_clean, m_clean, sw_changed, exp_chg());
      else passed++;
      if (sw_clean[3] === 1'b1 && !prev) begin
        rises++;
        rise_at = n;
      end
      prev = sw_clean[3];
    end
    checks++;
    if (rises != 1) $display("FAIL bounce_edges: %0d rising edges expected 1", rises);
    else passed++;
    checks++;
    if (rise_at != 13) $display("FAIL bounce_latency: rise at %0d expected 13", rise_at);
    else passed++;
  endtask

  task automatic test_glitch();
    int bad = 0;
    quiesce();
    for (int k = 0; k < SAMPLE_DIV && (m_edges % SAMPLE_DIV) != 0; k++) cycle();
    sw_raw[5] = 1'b1;
    cycle();
    sw_raw[5] = 1'b0;
    for (int n = 0; n < 24; n++) begin
      cycle();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== exp_chg())
        $display("FAIL glitch: cyc %0d sw_clean=%h exp %h sw_changed=%h exp %h", n, sw_clean, m_clean, sw_changed, exp_chg());
      else passed++;
      if (sw_clean[5] !== 1'b0 || sw_changed[5] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL glitch_visible: %0d cycles with bit5 set expected 0", bad);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int rise0 = -1;
    int rise9 = -1;
    int pulses = 0;
    quiesce();
    sw_raw = 10'h201;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== exp_chg())
        $display("FAIL simultaneous: cyc %0d sw_clean=%h exp %h sw_changed=%h exp %h", n, sw_clean, m_clean, sw_changed, exp_chg());
      else passed++;
      if (rise0 < 0 && sw_clean[0] === 1'b1) rise0 = n;
      if (rise9 < 0 && sw_clean[9] === 1'b1) rise9 = n;
      if (sw_changed === 10'h201) pulses++;
    end
    checks++;
    if (rise0 != rise9 || rise0 < 11 || rise0 > 14)
      $display("FAIL simul_edge: bit0 at %0d bit9 at %0d expected equal in 11..14", rise0, rise9);
    else passed++;
    checks++;
    if (pulses != EXP_PULSES) $display("FAIL simul_pulse: %0d pulses expected %0d", pulses, EXP_PULSES);
    else passed++;
  endtask

  task automatic test_reset_mid_count();
    int ticks = 0;
    int rise = -1;
    quiesce();
    sw_raw[2] = 1'b1;
    for (int k = 0; k < 20 && ticks < 2; k++) begin
      cycle();
      if ((m_edges % SAMPLE_DIV) == 0) ticks++;
    end
    checks++;
    if (sw_clean !== m_clean) $display("FAIL mid_precount: sw_clean=%h expected %h", sw_clean, m_clean);
    else passed++;
    assert_reset();
    checks++;
    if (sw_clean !== '0 || sw_changed !== '0)
      $display("FAIL mid_reset: sw_clean=%h sw_changed=%h expected 0/0", sw_clean, sw_changed);
    else passed++;
    cycle();
    cycle();
    reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== exp_chg())
        $display("FAIL mid_restart: cyc %0d sw_clean=%h exp %h sw_changed=%h exp %h", n, sw_clean, m_clean, sw_changed, exp_chg());
      else passed++;
      if (rise < 0 && sw_clean[2] === 1'b1) rise = n;
    end
    checks++;
    if (rise < 11 || rise > 14) $display("FAIL mid_latency: rise at %0d expected 11..14", rise);
    else passed++;
  endtask

  task automatic test_random();
    int hold = 0;
    quiesce();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        checks++;
        if (sw_clean !== '0 || sw_changed !== '0)
          $display("FAIL rand_reset: sw_clean=%h sw_changed=%h expected 0/0", sw_clean, sw_changed);
        else passed++;
        cycle();
        reset_n = 1'b1;
        hold = 0;
      end
      if (hold == 0) begin
        sw_raw = sw_raw ^ (WIDTH'($urandom) & WIDTH'($urandom));
        hold = int'($urandom_range(1, 18));
      end
      hold--;
      cycle();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== exp_chg())
        $display("FAIL random: cyc %0d sw_clean=%h exp %h sw_changed=%h exp %h", n, sw_clean, m_clean, sw_changed, exp_chg());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
